// File: rtl/tdm_select_sequencer.sv
// tdm_select_sequencer
// Time-division scan controller for a 4:1 MUX / 1:4 DEMUX pair. Walks the
// enabled channels in ascending order, holds each for dwell+1 cycles, samples
// the MUX output on the last cycle of every window and tags it with its channel.

module tdm_select_sequencer #(
   parameter int DW  = 4,
   parameter int FCW = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           stop,
   input  logic [3:0]     chan_mask,
   input  logic [DW-1:0]  dwell,
   input  logic           mux_out,
   output logic           s1,
   output logic           s0,
   output logic           busy,
   output logic           frame_start,
   output logic           sample,
   output logic [1:0]     sample_ch,
   output logic           sample_valid,
   output logic [FCW-1:0] frame_cnt
);

   // STOPPING is SCAN with a stop request pending; it ends the frame and idles
   typedef enum logic [1:0] {IDLE, SCAN, STOPPING} state_t;

   state_t         state_q, state_d;
   logic [1:0]     sel_q, sel_d;
   logic [DW-1:0]  dcnt_q, dcnt_d;
   logic [DW-1:0]  dwell_q, dwell_d;
   logic [3:0]     mask_q, mask_d;
   logic           frame_start_q, frame_start_d;
   logic           sample_q, sample_d;
   logic [1:0]     sample_ch_q, sample_ch_d;
   logic           sample_valid_q, sample_valid_d;
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

   logic [1:0]     low_live;
   logic [1:0]     next_sel;
   logic           has_next;

   assign s1           = sel_q[1];
   assign s0           = sel_q[0];
   assign busy         = (state_q != IDLE);
   assign frame_start  = frame_start_q;
   assign sample       = sample_q;
   assign sample_ch    = sample_ch_q;
   assign sample_valid = sample_valid_q;
   assign frame_cnt    = frame_cnt_q;

   // Lowest enabled channel of the live mask, used when a frame (re)starts
   always_comb begin
      low_live = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (chan_mask[i]) low_live = i[1:0];
      end
   end

   // Next higher enabled channel of the latched mask; has_next=0 means wrap
   always_comb begin
      has_next = 1'b0;
      next_sel = sel_q;
      for (int i = 3; i >= 0; i--) begin
         if ((i > int'(sel_q)) && mask_q[i]) begin
            has_next = 1'b1;
            next_sel = i[1:0];
         end
      end
   end

   // Next-state and registered-output logic for the scan sequencer
   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      dcnt_d         = dcnt_q;
      dwell_d        = dwell_q;
      mask_d         = mask_q;
      frame_start_d  = 1'b0;
      sample_d       = sample_q;
      sample_ch_d    = sample_ch_q;
      sample_valid_d = 1'b0;
      frame_cnt_d    = frame_cnt_q;

      case (state_q)
         IDLE: begin
            if (start && (chan_mask != 4'b0000)) begin
               state_d       = SCAN;
               mask_d        = chan_mask;
               dwell_d       = dwell;
               sel_d         = low_live;
               dcnt_d        = '0;
               frame_start_d = 1'b1;
            end
         end
         SCAN, STOPPING: begin
            if ((state_q == SCAN) && stop) state_d = STOPPING;
            if (dcnt_q == dwell_q) begin
               sample_d       = mux_out;
               sample_ch_d    = sel_q;
               sample_valid_d = 1'b1;
               dcnt_d         = '0;
               if (has_next) begin
                  sel_d = next_sel;
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
                  // A stop arriving on the wrap cycle itself also ends the scan
                  if ((state_q == STOPPING) || stop || (chan_mask == 4'b0000)) begin
                     state_d = IDLE;
                     sel_d   = 2'd0;
                  end else begin
                     mask_d        = chan_mask;
                     dwell_d       = dwell;
                     sel_d         = low_live;
                     frame_start_d = 1'b1;
                  end
               end
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = 2'd0;
         end
      endcase
   end

   // State and output registers; reset aborts any scan without a sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         sel_q          <= 2'd0;
         dcnt_q         <= '0;
         dwell_q        <= '0;
         mask_q         <= 4'b0000;
         frame_start_q  <= 1'b0;
         sample_q       <= 1'b0;
         sample_ch_q    <= 2'd0;
         sample_valid_q <= 1'b0;
         frame_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         sel_q          <= sel_d;
         dcnt_q         <= dcnt_d;
         dwell_q        <= dwell_d;
         mask_q         <= mask_d;
         frame_start_q  <= frame_start_d;
         sample_q       <= sample_d;
         sample_ch_q    <= sample_ch_d;
         sample_valid_q <= sample_valid_d;
         frame_cnt_q    <= frame_cnt_d;
      end
   end

endmodule

// File: tb/tb_tdm_select_sequencer.sv
// tb_tdm_select_sequencer
// Directed scans of the sequencer with a behavioural 4:1 MUX in the loop.
// Expected samples are queued when a scan is issued and retired by a monitor.

module tb_tdm_select_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic [3:0] chan_mask;
   logic [3:0] dwell;
   logic       mux_out;
   logic       s1, s0, busy, frame_start, sample, sample_valid;
   logic [1:0] sample_ch;
   logic [7:0] frame_cnt;

   logic [3:0] muxIn;
   logic [1:0] expLow;
   int         expFrameCnt;
   int         checkCount;
   int         failCount;
   int         cycle;
   int         lastSampleCycle;

   typedef struct {
      logic [1:0] ch;
      logic       bitVal;
      int         gap;
      bit         last;
   } exp_t;

   exp_t expQ[$];

   tdm_select_sequencer #(.DW(4), .FCW(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .stop         (stop),
      .chan_mask    (chan_mask),
      .dwell        (dwell),
      .mux_out      (mux_out),
      .s1           (s1),
      .s0           (s0),
      .busy         (busy),
      .frame_start  (frame_start),
      .sample       (sample),
      .sample_ch    (sample_ch),
      .sample_valid (sample_valid),
      .frame_cnt    (frame_cnt)
   );

   // Behavioural combinational 4:1 MUX steered by the DUT select lines
   assign mux_out = muxIn[{s1, s0}];

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
      end
   endtask

   function automatic logic [1:0] lowestOf(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      if (m[3]) r = 2'd3;
      if (m[2]) r = 2'd2;
      if (m[1]) r = 2'd1;
      if (m[0]) r = 2'd0;
      return r;
   endfunction

   // Monitor: retire one queued sample per sample_valid, check frame-start select
   always @(negedge clk) begin
      exp_t e;
      cycle++;
      if (rst_n && sample_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_sample_ch", {30'd0, sample_ch}, 32'hFFFF_FFFF);
         end else begin
            e = expQ.pop_front();
            checkOutput("sample_ch", {30'd0, sample_ch}, {30'd0, e.ch});
            checkOutput("sample_bit", {31'd0, sample}, {31'd0, e.bitVal});
            checkOutput("busy_with_sample", {31'd0, busy}, e.last ? 32'd0 : 32'd1);
            if (e.gap > 0) checkOutput("sample_gap", cycle - lastSampleCycle, e.gap);
         end
         lastSampleCycle = cycle;
      end
      if (rst_n && frame_start) checkOutput("frame_start_sel", {30'd0, s1, s0}, {30'd0, expLow});
   end

   // Issue one scan: queue its samples, start it, end it by stop or by a mask drop
   task automatic applyStimulus(input logic [3:0] mask, input logic [3:0] dw, input logic [3:0] ins,
                                input int nframes, input logic [1:0] stopCh, input bit dropMask);
      int seen;
      int guard;
      bit first;
      exp_t e;
      muxIn  = ins;
      expLow = lowestOf(mask);
      first  = 1'b1;
      for (int f = 0; f < nframes; f++) begin
         for (int ch = 0; ch < 4; ch++) begin
            if (mask[ch]) begin
               e.ch     = ch[1:0];
               e.bitVal = ins[ch];
               e.gap    = first ? 0 : int'(dw) + 1;
               e.last   = 1'b0;
               expQ.push_back(e);
               first = 1'b0;
            end
         end
      end
      expQ[expQ.size()-1].last = 1'b1;

      @(negedge clk);
      chan_mask = mask;
      dwell     = dw;
      start     = 1'b1;
      seen  = 0;
      guard = 0;
      while (seen < nframes && guard < 500) begin
         @(negedge clk);
         start = 1'b0;
         guard++;
         if (frame_start) seen++;
      end
      if (guard >= 500) checkOutput("frame_start_timeout", seen, nframes);

      if (dropMask) begin
         chan_mask = 4'b0000;
      end else begin
         guard = 0;
         while ({s1, s0} != stopCh && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 200) checkOutput("stop_channel_timeout", {30'd0, s1, s0}, {30'd0, stopCh});
         stop = 1'b1;
         @(negedge clk);
         stop = 1'b0;
      end

      guard = 0;
      while (busy && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) checkOutput("busy_timeout", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      expFrameCnt = (expFrameCnt + nframes) % 256;
   endtask

   // End-of-scan idle state and bookkeeping checks
   task automatic checkIdle(input string tag);
      checkOutput({tag, "_pending_samples"}, expQ.size(), 0);
      checkOutput({tag, "_frame_cnt"}, {24'd0, frame_cnt}, expFrameCnt);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_sel"}, {30'd0, s1, s0}, 32'd0);
   endtask

   // Directed sequence of scans
   initial begin
      checkCount      = 0;
      failCount       = 0;
      cycle           = 0;
      lastSampleCycle = 0;
      expFrameCnt     = 0;
      expLow          = 2'd0;
      muxIn           = 4'b0000;
      rst_n           = 1'b0;
      start           = 1'b0;
      stop            = 1'b0;
      chan_mask       = 4'b0000;
      dwell           = 4'd0;

      repeat (2) @(negedge clk);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_sel", {30'd0, s1, s0}, 32'd0);
      checkOutput("reset_sample_valid", {31'd0, sample_valid}, 32'd0);
      checkOutput("reset_frame_start", {31'd0, frame_start}, 32'd0);
      checkOutput("reset_frame_cnt", {24'd0, frame_cnt}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] T1 mask=1111 dwell=0, two frames");
      applyStimulus(4'b1111, 4'd0, 4'b1010, 2, 2'd0, 1'b0);
      checkIdle("t1");

      $display("[TB] T2 mask=1010 dwell=2, two frames");
      applyStimulus(4'b1010, 4'd2, 4'b0110, 2, 2'd1, 1'b0);
      checkIdle("t2");

      $display("[TB] T3 inputs a=0 b=1 c=0 d=1, mask=1111 dwell=1");
      applyStimulus(4'b1111, 4'd1, 4'b1010, 1, 2'd0, 1'b0);
      checkIdle("t3");

      $display("[TB] T4 stop during ch1");
      applyStimulus(4'b1111, 4'd3, 4'b0101, 1, 2'd1, 1'b0);
      checkIdle("t4");

      $display("[TB] T5 mask dropped mid-frame, then start with empty mask");
      applyStimulus(4'b1111, 4'd1, 4'b1100, 1, 2'd0, 1'b1);
      checkIdle("t5");
      @(negedge clk);
      chan_mask = 4'b0000;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("t5_empty_start_busy", {31'd0, busy}, 32'd0);

      $display("[TB] T6 reset mid-dwell");
      @(negedge clk);
      chan_mask = 4'b1111;
      dwell     = 4'd5;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checkOutput("t6_busy_before_reset", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_busy", {31'd0, busy}, 32'd0);
      checkOutput("t6_frame_cnt", {24'd0, frame_cnt}, 32'd0);
      checkOutput("t6_sample", {29'd0, sample_ch, sample}, 32'd0);
      checkOutput("t6_sel", {30'd0, s1, s0}, 32'd0);
      expFrameCnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(4'b1111, 4'd1, 4'b1010, 1, 2'd0, 1'b0);
      checkIdle("t6");

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
